// File: rtl/zipdbg_pkg.sv
// Shared definitions for the ZipCPU debug-port sequencer.
//   seq_state_e : sequencer FSM states
//   CTL_*       : bit positions inside the CPU debug control register
//   DBG_*       : debug-slave register addresses
//   ctl_word()  : builds a well-formed control-register write value
package zipdbg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StPoll,
        StData,
        StResume,
        StDone,
        StErr
    } seq_state_e;

    localparam int unsigned CTL_HALT     = 10;
    localparam int unsigned CTL_READY    = 9;
    localparam int unsigned CTL_ADDR_MSB = 4;

    localparam logic DBG_CTRL = 1'b0;
    localparam logic DBG_DATA = 1'b1;

    // Reset, step and cache-clear bits are left at zero on purpose: the sequencer only ever
    // halts/releases the CPU and selects a register.
    function automatic logic [31:0] ctl_word(input logic halt, input logic [4:0] rsel);
        logic [31:0] w;
        w                   = '0;
        w[CTL_HALT]         = halt;
        w[CTL_ADDR_MSB:0]   = rsel;
        return w;
    endfunction

endpackage

// File: rtl/zipdbg_wbxact.sv
// Single-transaction Wishbone master for the debug port.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   start_i                   : launch a transaction with we_i/addr_i/wdata_i (may coincide
//                               with done_o/timeout_o to chain transactions back to back)
//   stb_o, we_o, addr_o,
//   wdata_o                   : Wishbone request fields, held for the whole transaction
//   dbg_ack_i, dbg_stall_i,
//   dbg_data_i                : Wishbone response side
//   done_o                    : ack received this cycle (rdata_o valid)
//   timeout_o                 : transaction abandoned this cycle
//   rdata_o                   : read data accompanying done_o
module zipdbg_wbxact #(
    parameter int unsigned TIMEOUT_BITS = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        we_i,
    input  logic        addr_i,
    input  logic [31:0] wdata_i,
    output logic        stb_o,
    output logic        we_o,
    output logic        addr_o,
    output logic [31:0] wdata_o,
    input  logic        dbg_ack_i,
    input  logic        dbg_stall_i,
    input  logic [31:0] dbg_data_i,
    output logic        done_o,
    output logic        timeout_o,
    output logic [31:0] rdata_o
);

    // A transaction may occupy at most 2^TIMEOUT_BITS-1 cycles: the cycle whose count would
    // step onto all-ones is the last one in which an ack is still accepted.
    localparam logic [TIMEOUT_BITS-1:0] CntLast = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

    logic                    active_q, active_d;
    logic                    stb_q, stb_d;
    logic                    we_q, we_d;
    logic                    addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        active_d  = active_q;
        stb_d     = stb_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        done_o    = 1'b0;
        timeout_o = 1'b0;

        if (active_q) begin
            if (stb_q && !dbg_stall_i) begin
                stb_d = 1'b0;
            end
            // Ack is honoured while stb is still up, so a zero-wait slave completes in one cycle.
            if (dbg_ack_i) begin
                done_o   = 1'b1;
                active_d = 1'b0;
                stb_d    = 1'b0;
            end else if (cnt_q == CntLast) begin
                timeout_o = 1'b1;
                active_d  = 1'b0;
                stb_d     = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (start_i) begin
            active_d = 1'b1;
            stb_d    = 1'b1;
            cnt_d    = '0;
            we_d     = we_i;
            addr_d   = addr_i;
            wdata_d  = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 1'b0;
            wdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stb_o   = stb_q;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign rdata_o = dbg_data_i;

endmodule

// File: rtl/zipdbg_sequencer.sv
// Host-side ZipCPU debug sequencer: turns one register read/write request into
// halt -> poll-ready -> data access -> optional release on the debug Wishbone port.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_req, i_req_we,
//   i_req_reg, i_req_data,
//   i_req_resume            : request, accepted when i_req && !o_busy
//   o_busy                  : sequence in progress
//   o_done, o_err           : one-cycle completion pulse, with error flag
//   o_rd_data               : read result, valid with o_done && !o_err
//   o_dbg_*, i_dbg_*        : debug Wishbone master port (addr 0 control, 1 data)
module zipdbg_sequencer
    import zipdbg_pkg::*;
#(
    parameter int unsigned TIMEOUT_BITS = 10,
    parameter int unsigned POLL_LIMIT   = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_req_we,
    input  logic [4:0]  i_req_reg,
    input  logic [31:0] i_req_data,
    input  logic        i_req_resume,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rd_data,
    output logic        o_dbg_cyc,
    output logic        o_dbg_stb,
    output logic        o_dbg_we,
    output logic        o_dbg_addr,
    output logic [31:0] o_dbg_data,
    input  logic        i_dbg_ack,
    input  logic        i_dbg_stall,
    input  logic [31:0] i_dbg_data
);

    localparam int unsigned      PollW   = $clog2(POLL_LIMIT + 1);
    localparam logic [PollW-1:0] PollMax = PollW'(POLL_LIMIT);

    seq_state_e       state_q, state_d;
    logic             we_q, we_d;
    logic [4:0]       reg_q, reg_d;
    logic [31:0]      data_q, data_d;
    logic             resume_q, resume_d;
    logic [31:0]      rd_q, rd_d;
    logic [PollW-1:0] poll_q, poll_d;
    logic [PollW-1:0] poll_inc;

    logic             xact_start;
    logic             xact_we;
    logic             xact_addr;
    logic [31:0]      xact_wdata;
    logic             xact_done;
    logic             xact_timeout;
    logic [31:0]      xact_rdata;
    logic             in_bt;

    assign in_bt    = state_q inside {StHalt, StPoll, StData, StResume};
    assign poll_inc = (poll_q == PollMax) ? poll_q : poll_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        reg_d      = reg_q;
        data_d     = data_q;
        resume_d   = resume_q;
        rd_d       = rd_q;
        poll_d     = poll_q;
        xact_start = 1'b0;
        xact_we    = 1'b0;
        xact_addr  = DBG_CTRL;
        xact_wdata = '0;

        unique case (state_q)
            // DONE/ERR do not count as busy, so a new request may chain straight in.
            StIdle, StDone, StErr: begin
                if (i_req) begin
                    we_d       = i_req_we;
                    reg_d      = i_req_reg;
                    data_d     = i_req_data;
                    resume_d   = i_req_resume;
                    poll_d     = '0;
                    state_d    = StHalt;
                    xact_start = 1'b1;
                    xact_we    = 1'b1;
                    xact_wdata = ctl_word(1'b1, i_req_reg);
                end else begin
                    state_d = StIdle;
                end
            end
            StHalt: begin
                if (xact_done) begin
                    state_d    = StPoll;
                    xact_start = 1'b1;
                end else if (xact_timeout) begin
                    state_d = StErr;
                end
            end
            StPoll: begin
                if (xact_done) begin
                    if (xact_rdata[CTL_READY]) begin
                        state_d    = StData;
                        xact_start = 1'b1;
                        xact_we    = we_q;
                        xact_addr  = DBG_DATA;
                        xact_wdata = we_q ? data_q : 32'h0;
                    end else begin
                        poll_d = poll_inc;
                        if (poll_inc == PollMax) begin
                            state_d = StErr;
                        end else begin
                            xact_start = 1'b1;
                        end
                    end
                end else if (xact_timeout) begin
                    state_d = StErr;
                end
            end
            StData: begin
                if (xact_done) begin
                    if (!we_q) begin
                        rd_d = xact_rdata;
                    end
                    if (resume_q) begin
                        state_d    = StResume;
                        xact_start = 1'b1;
                        xact_we    = 1'b1;
                        xact_wdata = ctl_word(1'b0, reg_q);
                    end else begin
                        state_d = StDone;
                    end
                end else if (xact_timeout) begin
                    state_d = StErr;
                end
            end
            StResume: begin
                if (xact_done) begin
                    state_d = StDone;
                end else if (xact_timeout) begin
                    state_d = StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            reg_q    <= '0;
            data_q   <= '0;
            resume_q <= 1'b0;
            rd_q     <= '0;
            poll_q   <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
            resume_q <= resume_d;
            rd_q     <= rd_d;
            poll_q   <= poll_d;
        end
    end

    zipdbg_wbxact #(
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) u_xact (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .start_i     (xact_start),
        .we_i        (xact_we),
        .addr_i      (xact_addr),
        .wdata_i     (xact_wdata),
        .stb_o       (o_dbg_stb),
        .we_o        (o_dbg_we),
        .addr_o      (o_dbg_addr),
        .wdata_o     (o_dbg_data),
        .dbg_ack_i   (i_dbg_ack),
        .dbg_stall_i (i_dbg_stall),
        .dbg_data_i  (i_dbg_data),
        .done_o      (xact_done),
        .timeout_o   (xact_timeout),
        .rdata_o     (xact_rdata)
    );

    assign o_busy    = in_bt;
    assign o_dbg_cyc = in_bt;
    assign o_done    = (state_q == StDone) || (state_q == StErr);
    assign o_err     = (state_q == StErr);
    assign o_rd_data = rd_q;

endmodule
